// File: rtl/ps2_mouse_host.sv
// ---------------------------------------------------------------------------
// ps2_mouse_host
//
// PS/2 mouse host controller. After reset it inhibits the bus and sends one
// command byte (CMD_BYTE, "enable data reporting" by default). It then waits
// for the mouse's acknowledge and, from then on, receives 3-byte movement
// packets and presents each complete packet to the CPU.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles MOUSE_CLOCK is held low before transmitting
//   CMD_BYTE        command byte sent once after reset
//   FRAME_TIMEOUT   idle clk cycles after which a partial frame is dropped
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   io_cs        CPU chip select
//   addr         0 = data (read clears RDA), 1 = status (no side effect)
//   data_out     last packet {status, X, Y}
//   RDA          received-data-available flag
//   t_clk        high while the host pulls MOUSE_CLOCK low
//   m_ack        sticky: mouse acknowledged the command byte
//   MOUSE_CLOCK  open-drain PS/2 clock
//   MOUSE_DATA   open-drain PS/2 data
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, a packet containing a byte with bad
//                        odd parity is dropped; otherwise parity is ignored.
// ---------------------------------------------------------------------------
module ps2_mouse_host #(
    parameter int         INHIBIT_CYCLES = 10000,
    parameter logic [7:0] CMD_BYTE       = 8'hF4,
    parameter int         FRAME_TIMEOUT  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_cs,
    input  logic        addr,
    output logic [23:0] data_out,
    output logic        RDA,
    output logic        t_clk,
    output logic        m_ack,
    inout  wire         MOUSE_CLOCK,
    inout  wire         MOUSE_DATA
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FRAME_TIMEOUT - 1);

    // Bits the host shifts out, indexed by falling-edge count:
    // data LSB first, odd parity, then a released (1) stop bit.
    localparam logic [9:0] TX_FRAME = {1'b1, ~(^CMD_BYTE), CMD_BYTE};

    typedef enum logic [2:0] {
        INHIBIT,
        REQ,
        TX,
        ACK,
        RX
    } state_t;

    state_t state, state_next;

    logic [1:0]       mclk_sync, mdat_sync;
    logic             mclk_prev;
    logic             mclk_fall;
    logic             mdat;
    logic             data_low, data_low_next;
    logic             t_clk_next;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  idle_cnt;
    logic [3:0]       bit_cnt;
    logic [1:0]       byte_cnt;
    logic [7:0]       rx_shift;
    logic [7:0]       byte1, byte2;
    logic             pkt_err;
    logic             rx_par_bad;

    // Open-drain drivers: only ever pull low, otherwise release the line.
    assign MOUSE_CLOCK = t_clk    ? 1'b0 : 1'bz;
    assign MOUSE_DATA  = data_low ? 1'b0 : 1'bz;

    // Two-flop synchronizers for both PS/2 lines plus a delayed copy of the
    // clock for falling-edge detection. Reset to the idle-high line level so
    // no false edge appears when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mclk_sync <= 2'b11;
            mdat_sync <= 2'b11;
            mclk_prev <= 1'b1;
        end else begin
            mclk_sync <= {mclk_sync[0], MOUSE_CLOCK};
            mdat_sync <= {mdat_sync[0], MOUSE_DATA};
            mclk_prev <= mclk_sync[1];
        end
    end

    assign mclk_fall  = mclk_prev & ~mclk_sync[1];
    assign mdat       = mdat_sync[1];
    assign rx_par_bad = ~(^{rx_shift, mdat});

    // State and registered line controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INHIBIT;
            t_clk    <= 1'b0;
            data_low <= 1'b0;
        end else begin
            state    <= state_next;
            t_clk    <= t_clk_next;
            data_low <= data_low_next;
        end
    end

    // Next state and next line controls. The line controls are registered,
    // so the values chosen here are those that apply in the next state.
    always_comb begin
        state_next    = state;
        t_clk_next    = 1'b0;
        data_low_next = 1'b0;
        case (state)
            INHIBIT: begin
                t_clk_next = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    state_next    = REQ;
                    data_low_next = 1'b1;
                end
            end
            REQ: begin
                // Start bit stays on the line until the first falling edge.
                state_next    = TX;
                data_low_next = 1'b1;
            end
            TX: begin
                data_low_next = data_low;
                if (mclk_fall) begin
                    data_low_next = ~TX_FRAME[bit_cnt];
                    if (bit_cnt == 4'd9) begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (mclk_fall) begin
                    state_next = RX;
                end
            end
            RX: begin
                state_next = RX;
            end
            default: begin
                state_next = INHIBIT;
            end
        endcase
    end

    // Command acknowledge: the mouse pulls data low on the edge after stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack <= 1'b0;
        end else if (state == ACK && mclk_fall && !mdat) begin
            m_ack <= 1'b1;
        end
    end

    // Counters, receive datapath and CPU-visible packet register. The CPU
    // clear of RDA comes first so a packet completing in the same cycle
    // overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_cnt  <= '0;
            idle_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_shift <= '0;
            byte1    <= '0;
            byte2    <= '0;
            pkt_err  <= 1'b0;
            data_out <= '0;
            RDA      <= 1'b0;
        end else begin
            if (io_cs && !addr) begin
                RDA <= 1'b0;
            end
            case (state)
                INHIBIT: begin
                    if (inh_cnt != INH_LAST) begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                TX: begin
                    if (mclk_fall) begin
                        bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                RX: begin
                    if (mclk_fall) begin
                        idle_cnt <= '0;
                        if (bit_cnt == 4'd0) begin
                            // A high start bit is noise: stay idle.
                            if (!mdat) begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (bit_cnt <= 4'd8) begin
                            rx_shift <= {mdat, rx_shift[7:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd9) begin
                            if (PAR_CHECK && rx_par_bad) begin
                                pkt_err <= 1'b1;
                            end
                            bit_cnt <= 4'd10;
                        end else begin
                            bit_cnt <= 4'd0;
                            if (!mdat) begin
                                // Framing error: drop the whole packet.
                                byte_cnt <= 2'd0;
                                pkt_err  <= 1'b0;
                            end else begin
                                case (byte_cnt)
                                    2'd0: begin
                                        byte1    <= rx_shift;
                                        byte_cnt <= 2'd1;
                                    end
                                    2'd1: begin
                                        byte2    <= rx_shift;
                                        byte_cnt <= 2'd2;
                                    end
                                    default: begin
                                        byte_cnt <= 2'd0;
                                        pkt_err  <= 1'b0;
                                        if (!pkt_err) begin
                                            data_out <= {byte1, byte2, rx_shift};
                                            RDA      <= 1'b1;
                                        end
                                    end
                                endcase
                            end
                        end
                    end else if (bit_cnt != 4'd0 || byte_cnt != 2'd0) begin
                        // A partial byte or packet has stalled too long.
                        if (idle_cnt == TO_LAST) begin
                            idle_cnt <= '0;
                            bit_cnt  <= 4'd0;
                            byte_cnt <= 2'd0;
                            pkt_err  <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + TO_W'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_host.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_host
//
// Directed bench for ps2_mouse_host. Plays the mouse side of the bus: clocks
// out the host's command byte, acknowledges it, then sends packets from a
// vector table and a few hand-written corner-case sequences.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_host;

    localparam int INHIBIT = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_cs;
    logic        addr;
    logic [23:0] data_out;
    logic        RDA;
    logic        t_clk;
    logic        m_ack;
    wire         mouse_clock;
    wire         mouse_data;

    logic        mclk_low;
    logic        mdat_low;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic        par2_bad;
        logic        stop3_bad;
        logic [23:0] exp_data;
        logic        exp_rda;
    } vec_t;

    vec_t vecs[6];

    pullup (mouse_clock);
    pullup (mouse_data);

    assign mouse_clock = mclk_low ? 1'b0 : 1'bz;
    assign mouse_data  = mdat_low ? 1'b0 : 1'bz;

    ps2_mouse_host dut (
        .clk         (clk),
        .rst         (rst),
        .io_cs       (io_cs),
        .addr        (addr),
        .data_out    (data_out),
        .RDA         (RDA),
        .t_clk       (t_clk),
        .m_ack       (m_ack),
        .MOUSE_CLOCK (mouse_clock),
        .MOUSE_DATA  (mouse_data)
    );

    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One mouse-to-host bit: data set while clock high, then a low pulse.
    task automatic mouseBit(input logic b);
        mdat_low = ~b;
        #60;
        mclk_low = 1'b1;
        #60;
        mclk_low = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        mouseBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            mouseBit(b[i]);
        end
        mouseBit(par);
        mouseBit(~bad_stop);
        mdat_low = 1'b0;
        #200;
    endtask

    task automatic applyStimulus(input vec_t v);
        sendByte(v.b1, 1'b0, 1'b0);
        sendByte(v.b2, v.par2_bad, 1'b0);
        sendByte(v.b3, 1'b0, v.stop3_bad);
    endtask

    // One-cycle CPU access.
    task automatic cpuRead(input logic a);
        @(negedge clk);
        io_cs = 1'b1;
        addr  = a;
        @(negedge clk);
        io_cs = 1'b0;
        addr  = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          hi_cnt;
        logic        released;
        logic        clk_line_ok;
        logic        data_rel_ok;
        logic        req_data;
        logic        seen;
        logic [9:0]  tx_exp;
        logic        sample;

        vecs[0] = '{8'h08, 8'h05, 8'hFB, 1'b0, 1'b0, 24'h0805FB, 1'b1};
        vecs[1] = '{8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 24'h123456, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 24'hFF0080, 1'b1};
        vecs[3] = '{8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 24'hFF0080, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        vecs[4] = '{8'h44, 8'h55, 8'h66, 1'b1, 1'b0, 24'hFF0080, 1'b0};
`else
        vecs[4] = '{8'h44, 8'h55, 8'h66, 1'b1, 1'b0, 24'h445566, 1'b1};
`endif
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 24'h000000, 1'b1};

        rst      = 1'b1;
        io_cs    = 1'b0;
        addr     = 1'b0;
        mclk_low = 1'b0;
        mdat_low = 1'b0;

        $display("[TB] reset checks");
        #23;
        checkOutput("reset t_clk", t_clk, 1'b0);
        checkOutput("reset RDA", RDA, 1'b0);
        checkOutput("reset m_ack", m_ack, 1'b0);
        checkOutput("reset data_out", data_out, 24'h0);
        checkOutput("reset clock line", mouse_clock, 1'b1);
        checkOutput("reset data line", mouse_data, 1'b1);

        @(negedge clk);
        rst = 1'b0;

        // Inhibit then request-to-send.
        hi_cnt      = 0;
        released    = 1'b0;
        clk_line_ok = 1'b1;
        data_rel_ok = 1'b1;
        req_data    = 1'b1;
        for (int n = 0; n < INHIBIT + 2000 && !released; n++) begin
            @(negedge clk);
            if (t_clk === 1'b1) begin
                hi_cnt++;
                if (mouse_clock !== 1'b0) clk_line_ok = 1'b0;
                if (hi_cnt < INHIBIT && mouse_data !== 1'b1) data_rel_ok = 1'b0;
                req_data = mouse_data;
            end else begin
                released = 1'b1;
            end
        end
        checkOutput("clock released", released, 1'b1);
        checkOutput("inhibit length", hi_cnt, INHIBIT);
        checkOutput("clock held low", clk_line_ok, 1'b1);
        checkOutput("data free in inhibit", data_rel_ok, 1'b1);
        checkOutput("start bit with clock held", req_data, 1'b0);
        checkOutput("clock line after release", mouse_clock, 1'b1);
        checkOutput("start bit after release", mouse_data, 1'b0);

        // Host transmits F4: 0,0,1,0,1,1,1,1, parity 0, stop released.
        tx_exp = 10'b10_1111_0100;
        for (int i = 0; i < 10; i++) begin
            #60;
            mclk_low = 1'b1;
            #60;
            sample = mouse_data;
            checkOutput($sformatf("tx bit %0d", i), sample, tx_exp[i]);
            mclk_low = 1'b0;
        end
        checkOutput("m_ack before ack", m_ack, 1'b0);
        mdat_low = 1'b1;
        #60;
        mclk_low = 1'b1;
        #60;
        mclk_low = 1'b0;
        #60;
        mdat_low = 1'b0;
        #100;
        checkOutput("m_ack after ack", m_ack, 1'b1);
        checkOutput("RDA before packets", RDA, 1'b0);

        // Packet table: status read leaves RDA, data read clears it.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d RDA", i), RDA, vecs[i].exp_rda);
            cpuRead(1'b1);
            checkOutput($sformatf("vec%0d RDA after status read", i), RDA, vecs[i].exp_rda);
            cpuRead(1'b0);
            checkOutput($sformatf("vec%0d RDA after data read", i), RDA, 1'b0);
            checkOutput($sformatf("vec%0d data_out after read", i), data_out, vecs[i].exp_data);
        end

        // Completion while the CPU keeps clearing: the set must win.
        $display("[TB] set versus clear");
        seen  = 1'b0;
        @(negedge clk);
        io_cs = 1'b1;
        addr  = 1'b0;
        fork
            begin
                sendByte(8'h0A, 1'b0, 1'b0);
                sendByte(8'h0B, 1'b0, 1'b0);
                sendByte(8'h0C, 1'b0, 1'b0);
            end
            begin
                for (int n = 0; n < 3000 && !seen; n++) begin
                    @(negedge clk);
                    if (RDA === 1'b1) begin
                        seen  = 1'b1;
                        io_cs = 1'b0;
                    end
                end
            end
        join
        io_cs = 1'b0;
        @(negedge clk);
        checkOutput("set wins over clear", seen, 1'b1);
        checkOutput("set wins RDA held", RDA, 1'b1);
        checkOutput("set wins data_out", data_out, 24'h0A0B0C);
        cpuRead(1'b0);

        // Two bytes, long silence, then a fresh packet.
        $display("[TB] partial packet timeout");
        sendByte(8'h77, 1'b0, 1'b0);
        sendByte(8'h66, 1'b0, 1'b0);
        repeat (25000) @(negedge clk);
        checkOutput("timeout RDA", RDA, 1'b0);
        checkOutput("timeout data_out", data_out, 24'h0A0B0C);
        sendByte(8'h09, 1'b0, 1'b0);
        sendByte(8'h01, 1'b0, 1'b0);
        sendByte(8'h02, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("after timeout data_out", data_out, 24'h090102);
        checkOutput("after timeout RDA", RDA, 1'b1);

        // Reset in the middle of a byte.
        $display("[TB] mid-transaction reset");
        sendByte(8'h5A, 1'b0, 1'b0);
        mouseBit(1'b0);
        mouseBit(1'b1);
        mdat_low = 1'b0;
        mclk_low = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset data_out", data_out, 24'h0);
        checkOutput("mid reset RDA", RDA, 1'b0);
        checkOutput("mid reset m_ack", m_ack, 1'b0);
        checkOutput("mid reset t_clk", t_clk, 1'b0);
        checkOutput("mid reset clock line", mouse_clock, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("restart t_clk", t_clk, 1'b1);
        checkOutput("restart clock line", mouse_clock, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_host.md
PS2_MOUSE_HOST -- requirements
Module: ps2_mouse_host

Interface
- REQ-001 Parameter INHIBIT_CYCLES, default 10000, number of clk cycles the host holds MOUSE_CLOCK low before transmitting (100 us at 100 MHz).
- REQ-002 Parameter CMD_BYTE, default 8'hF4, command byte sent once after reset ("enable data reporting").
- REQ-003 Parameter FRAME_TIMEOUT, default 20000, clk cycles without a mouse-clock falling edge after which a partial receive frame is discarded.
- REQ-004 Clocking: one clock; reset is asynchronous and active-high.
- REQ-005 clk  input  1  system clock; all logic on rising edge.
- REQ-006 rst  input  1  asynchronous active-high reset.
- REQ-007 io_cs  input  1  CPU chip select for this block.
- REQ-008 addr  input  1  register select: 0 = data (read clears RDA), 1 = status (no side effect).
- REQ-009 data_out  output  24  last complete packet: [23:16] byte 1 (status), [15:8] byte 2 (X), [7:0] byte 3 (Y).
- REQ-010 RDA  output  1  received-data-available flag.
- REQ-011 t_clk  output  1  high while the host drives MOUSE_CLOCK low.
- REQ-012 m_ack  output  1  high once the mouse has acknowledged CMD_BYTE; sticky until reset.
- REQ-013 MOUSE_CLOCK  inout  1  PS/2 clock, open-drain: driven 0 when t_clk=1, else high-Z.
- REQ-014 MOUSE_DATA  inout  1  PS/2 data, open-drain: driven 0 only when host transmits a 0, else high-Z.

Function
- REQ-015 MOUSE_CLOCK and MOUSE_DATA are each passed through a 2-flop synchronizer; a mouse-clock falling edge is synced value 1 in the previous cycle and 0 in the current cycle.
- REQ-016 States: INHIBIT, REQ, TX, ACK, RX.
- REQ-017 INHIBIT: t_clk=1, data released; counter counts INHIBIT_CYCLES, then -> REQ.
- REQ-018 REQ: drive MOUSE_DATA low (start bit) for 1 cycle with clock still held, then t_clk=0 (clock released) -> TX.
- REQ-019 TX: on each falling edge present the next bit: CMD_BYTE[0..7] LSB first, odd parity, then release data (stop); after the 10th falling edge -> ACK.
- REQ-020 ACK: on the next falling edge sample data; 0 sets m_ack; 1 leaves m_ack=0; either way -> RX.
- REQ-021 RX: each byte is 11 bits sampled on falling edges: start (must be 0, else ignore edge and stay idle), 8 data LSB first, parity, stop.
- REQ-022 Three consecutive bytes form a packet; on the stop-bit edge of byte 3, data_out is loaded and RDA=1 in the next cycle.
- REQ-023 io_cs=1 with addr=0 clears RDA on the next edge; data_out holds its value.
- REQ-024 Packet completion and RDA clear in the same cycle: set wins (RDA=1).
- REQ-025 If FRAME_TIMEOUT cycles elapse with no falling edge while a byte or packet is partial, bit and byte counters reset to 0; data_out and RDA unchanged.
- REQ-026 Stop bit of 0 discards the current packet (counters to 0).
- REQ-027 No host transmission after the first command; RX is terminal until reset.

Reset
- REQ-028 rst asserted: state=INHIBIT, all counters 0, data_out=0, RDA=0, m_ack=0, t_clk=0, both lines high-Z.
- REQ-029 t_clk goes 1 on the first clk edge after rst deasserts; rst mid-transaction aborts it immediately and restarts from INHIBIT.

Configuration
- REQ-030 Macro PS2_PARITY_CHECK_EN: defined -> each received byte's odd parity is checked and a packet containing a parity error is discarded (no data_out/RDA update); undefined -> parity bit is sampled and ignored.

Verification
- REQ-031 Reset, 100 MHz clk -> t_clk=1 for 10000 cycles, MOUSE_CLOCK=0, then MOUSE_DATA=0, t_clk=0.
- REQ-032 Mouse clocks 60 ns half-period after release -> host emits 0,0,1,0,1,1,1,1 (F4), parity 0, releases data; mouse drives ack 0 -> m_ack=1.
- REQ-033 Mouse sends bytes 08, 05, FB with valid framing -> data_out=24'h0805FB, RDA=1.
- REQ-034 io_cs=1, addr=0 one cycle -> RDA=0 next cycle, data_out=24'h0805FB; addr=1 read -> RDA unchanged.
- REQ-035 Two bytes then 25000 idle cycles, then full packet 09,01,02 -> data_out=24'h090102 (partial discarded).
- REQ-036 With PS2_PARITY_CHECK_EN, byte 2 bad parity -> RDA stays 0, data_out unchanged.
